dac_writer_board: RTL and testbench
===================================

DAC_WRITER_BOARD -- requirements
Module: dac_writer_board

Interface
REQ-001 Parameter CLKDIV, default 2: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dac_enable  input  4  per-channel enable; bit n gates channel n.
REQ-005 dacdata  input  64  channel n value at [16n+15:16n]; bits [16n+11:16n] used, upper nibble ignored.
REQ-006 dacwrite  input  4  per-channel update request, one-cycle pulse.
REQ-007 dac1out  output  3  [0]=sync_n (active-low frame select), [1]=sclk, [2]=din.
REQ-008 dacbusy  output  1  high while a frame or inter-frame gap is in progress.
REQ-009 dacdone  output  4  one-cycle pulse on bit n when channel n frame completes.

Function
REQ-010 The block SHALL set pending[n] and capture dacdata[16n+11:16n] into a per-channel shadow register on any cycle with dacwrite[n] & dac_enable[n].
REQ-011 A write to a channel already pending SHALL overwrite its shadow and yield one transfer only (latest value wins).
REQ-012 dacwrite[n] with dac_enable[n] low SHALL be ignored; deasserting dac_enable[n] SHALL clear pending[n] unless that channel is already in flight.
REQ-013 A write to the channel currently in flight SHALL set a new pending without altering the frame in progress.
REQ-014 Arbitration SHALL be round-robin, starting the search at the channel after the last served (channel 0 after reset); selection occurs only in IDLE.
REQ-015 FSM states: IDLE -> LOAD (pending nonzero) -> SHIFT (16 bits) -> GAP -> IDLE.
REQ-016 LOAD SHALL clear the selected pending bit and form frame = {ch[1:0], 2'b01, shadow[11:0]}, MSB first.
REQ-017 Latency: dacwrite sampled at edge k SHALL give sync_n low from edge k+2 when IDLE and no other channel pending.
REQ-018 SHIFT: each bit SHALL last 2*CLKDIV cycles: sclk high CLKDIV cycles, then low CLKDIV cycles; din changes only at the start of the high half.
REQ-019 sync_n SHALL be low for exactly 32*CLKDIV cycles per frame; sclk SHALL idle high.
REQ-020 GAP SHALL hold sync_n high, sclk high, din 0 for 2*CLKDIV cycles.
REQ-021 dacdone[ch] SHALL pulse for one cycle on the first GAP cycle.
REQ-022 dacbusy SHALL be high in LOAD, SHIFT and GAP, and low in IDLE.
REQ-023 Simultaneous requests on several channels SHALL all be latched and served in round-robin order, one frame each.

Reset
REQ-024 On reset: sync_n=1, sclk=1, din=0, dacbusy=0, dacdone=0, pending=0, shadows=0, last-served pointer=3, FSM=IDLE, all effective at the next edge.
REQ-025 Reset mid-frame SHALL abort the frame immediately, produce no dacdone, and discard all pending requests.
REQ-026 Requests presented in the same cycle as reset SHALL be ignored.

Structure
REQ-027 Shared package dac_writer_pkg SHALL hold NUM_CH=4, FRAME_W=16, DATA_W=12, OP_WRITE_UPDATE=2'b01 and the FSM state enum.
REQ-028 The serializer (frame shift register, CLKDIV prescaler, bit counter) SHALL be one sub-module, spi_frame_tx; arbitration and shadows stay in the top.

Verification
REQ-029 CLKDIV=2, dacwrite[1] with data 0x0ABC: din shows 0x5ABC MSB-first, sync_n low 64 cycles, dacdone[1] pulses once.
REQ-030 dacwrite=4'hF in one cycle, data 0x0001/0x0002/0x0003/0x0004: frames 0x1001, 0x5002, 0x9003, 0xD004 in order, each separated by a 4-cycle gap.
REQ-031 dacwrite[2] 0x0100 then 0x0200 while channel 0 is in flight: exactly one channel-2 frame, 0x9200.
REQ-032 dac_enable=4'b0111, dacwrite[3] with 0xFFFF: no frame and dacbusy stays 0; with enable set, the frame is 0xDFFF (upper nibble ignored).
REQ-033 Reset asserted after bit 7 of a channel-0 frame with channel 1 pending: next edge sync_n=1, sclk=1, din=0, no dacdone, no further frames.
REQ-034 CLKDIV=1 back-to-back writes on channel 0: each frame is 32 cycles low plus a 2-cycle gap, with no lost request.

Source files
------------

// File: rtl/dac_writer_pkg.sv
// dac_writer_pkg
// Shared definitions for the 4-channel serial DAC writer: channel and frame
// geometry, the command opcode placed in every frame, the controller state
// encoding, and two small helpers (round-robin pick, frame assembly).
package dac_writer_pkg;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int FRAME_W = 16;
    localparam int DATA_W  = 12;

    localparam logic [1:0] OP_WRITE_UPDATE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } dac_state_t;

    // Round-robin pick: the first requesting channel after 'last', wrapping.
    // 'last' itself is checked last, so it is chosen only when it is the sole
    // requester. The loop runs from farthest to nearest so the nearest wins.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] idx;
        rr_pick = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + CH_W'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // Frame layout, sent MSB first: {channel, opcode, 12-bit value}.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [CH_W-1:0]   ch,
                                                      input logic [DATA_W-1:0] value);
        make_frame = {ch, OP_WRITE_UPDATE, value};
    endfunction

endpackage

// File: rtl/dac_writer_board_tx.sv
// spi_frame_tx
// Serializes one 16-bit frame onto a sync_n/sclk/din link.
// A 'start' pulse loads the frame and drops sync_n at the next edge. Each bit
// occupies 2*CLKDIV cycles: sclk high for CLKDIV cycles, then low for CLKDIV
// cycles; din only changes as sclk rises. After the last low half the link
// returns to idle (sync_n=1, sclk=1, din=0).
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse: begin sending 'frame'
//   frame      frame to send, MSB first (sampled with start)
//   sync_n     frame select, low for exactly 32*CLKDIV cycles per frame
//   sclk       serial clock, idles high
//   din        serial data
//   frame_end  high in the last cycle of the frame (combinational)
module spi_frame_tx
    import dac_writer_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               sync_n,
    output logic               sclk,
    output logic               din,
    output logic               frame_end
);

    localparam int               CNT_W      = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(FRAME_W - 1);
    localparam logic [7:0]       PRESC_LAST = 8'(CLKDIV - 1);

    logic [FRAME_W-1:0] shreg;     // bits still to send, next one at MSB
    logic [7:0]         presc;     // cycles elapsed in the current half-bit
    logic [CNT_W-1:0]   bit_cnt;   // index of the bit currently on din
    logic               active;
    logic               half_end;

    assign half_end  = active && (presc == PRESC_LAST);
    // The frame ends at the close of the low half of the last bit.
    assign frame_end = half_end && !sclk && (bit_cnt == BIT_LAST);

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            sync_n  <= 1'b1;
            sclk    <= 1'b1;
            din     <= 1'b0;
            shreg   <= '0;
            presc   <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sync_n  <= 1'b0;
            sclk    <= 1'b1;
            din     <= frame[FRAME_W-1];
            shreg   <= {frame[FRAME_W-2:0], 1'b0};
            presc   <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (half_end) begin
                presc <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                end else if (bit_cnt == BIT_LAST) begin
                    active <= 1'b0;
                    sync_n <= 1'b1;
                    sclk   <= 1'b1;
                    din    <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    sclk    <= 1'b1;
                    din     <= shreg[FRAME_W-1];
                    shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                end
            end else begin
                presc <= presc + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dac_writer_board.sv
// dac_writer_board
// Four-channel front end for a serial DAC. Each channel latches update
// requests into a shadow register plus a pending flag; a round-robin arbiter
// picks one pending channel at a time and hands a 16-bit frame
// {ch, 2'b01, value[11:0]} to the serializer. Every frame is followed by a
// guard gap of 2*CLKDIV cycles before the next selection.
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   dac_enable  per-channel enable; disabled channels ignore writes and lose
//               any pending request that is not already in flight
//   dacdata     channel n value in [16n+11:16n]; upper nibble unused
//   dacwrite    per-channel update request pulse
//   dac1out     {din, sclk, sync_n}
//   dacbusy     high in LOAD, SHIFT and GAP
//   dacdone     one-cycle pulse on the finished channel, first GAP cycle
module dac_writer_board
    import dac_writer_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dac_enable,
    input  logic [63:0] dacdata,
    input  logic [3:0]  dacwrite,
    output logic [2:0]  dac1out,
    output logic        dacbusy,
    output logic [3:0]  dacdone
);

    localparam logic [8:0] GAP_LAST = 9'(2 * CLKDIV - 1);

    dac_state_t          state;
    dac_state_t          state_next;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   pending_next;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [NUM_CH-1:0]   inflight;
    logic [DATA_W-1:0]   shadow [NUM_CH];
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     last_ch;
    logic [8:0]          gap_cnt;

    logic [FRAME_W-1:0]  tx_frame;
    logic                tx_start;
    logic                tx_sync_n;
    logic                tx_sclk;
    logic                tx_din;
    logic                tx_frame_end;

    // Only the low 12 bits of each channel word reach the DAC.
    logic unused_upper;
    assign unused_upper = ^{dacdata[63:60], dacdata[47:44], dacdata[31:28], dacdata[15:12]};

    assign accept    = dacwrite & dac_enable;
    // A request whose enable has just dropped is not eligible for selection.
    assign req       = pending & dac_enable;
    assign ch_onehot = NUM_CH'(1) << cur_ch;
    // The selected channel keeps any newer request even if its enable drops
    // while its frame is being loaded or shifted.
    assign inflight  = (state == ST_LOAD || state == ST_SHIFT) ? ch_onehot : '0;

    assign tx_start  = (state == ST_LOAD);
    assign tx_frame  = make_frame(cur_ch, shadow[cur_ch]);

    assign dac1out   = {tx_din, tx_sclk, tx_sync_n};
    assign dacbusy   = (state != ST_IDLE);

    // NOTE: every output of a combinational block gets a default on entry so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        pending_next = pending & (dac_enable | inflight);
        if (state == ST_LOAD) begin
            pending_next[cur_ch] = 1'b0;
        end
        // New writes win over the LOAD clear: a write to the channel being
        // loaded queues one more frame carrying the new value.
        pending_next = pending_next | accept;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|req)                    state_next = ST_LOAD;
            ST_LOAD:                               state_next = ST_SHIFT;
            ST_SHIFT: if (tx_frame_end)            state_next = ST_GAP;
            ST_GAP:   if (gap_cnt == GAP_LAST)     state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            pending <= '0;
            cur_ch  <= '0;
            last_ch <= CH_W'(NUM_CH - 1);
            gap_cnt <= '0;
            dacdone <= '0;
            // NOTE: the shadow array is cleared on reset; a channel can be
            // requested before it was ever written, and its frame must then
            // carry zero rather than an undefined value.
            for (int n = 0; n < NUM_CH; n++) begin
                shadow[n] <= '0;
            end
        end else begin
            state   <= state_next;
            pending <= pending_next;

            for (int n = 0; n < NUM_CH; n++) begin
                if (accept[n]) begin
                    shadow[n] <= dacdata[16*n +: DATA_W];
                end
            end

            if (state == ST_IDLE && |req) begin
                cur_ch  <= rr_pick(req, last_ch);
                last_ch <= rr_pick(req, last_ch);
            end

            gap_cnt <= (state == ST_GAP) ? gap_cnt + 9'd1 : 9'd0;
            dacdone <= (state == ST_SHIFT && tx_frame_end) ? ch_onehot : '0;
        end
    end

    spi_frame_tx #(
        .CLKDIV (CLKDIV)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .start     (tx_start),
        .frame     (tx_frame),
        .sync_n    (tx_sync_n),
        .sclk      (tx_sclk),
        .din       (tx_din),
        .frame_end (tx_frame_end)
    );

endmodule

// File: tb/tb_dac_writer_board.sv
// tb_dac_writer_board
// Directed bench: dut0 runs with CLKDIV=2, dut1 with CLKDIV=1. Frames are
// rebuilt from the serial pins by get_frame and compared with hand-computed
// words.
module tb_dac_writer_board;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dac_enable = 4'hF;
    logic [63:0] dacdata = '0;
    logic [3:0]  dacwrite0 = '0;
    logic [3:0]  dacwrite1 = '0;
    logic [2:0]  out0, out1;
    logic        busy0, busy1;
    logic [3:0]  done0, done1;

    int checks = 0;
    int passed = 0;
    int done_cnt [4] = '{default: 0};

    always #5 clk = ~clk;

    dac_writer_board #(.CLKDIV(2)) dut0 (
        .clk(clk), .reset(reset), .dac_enable(dac_enable), .dacdata(dacdata),
        .dacwrite(dacwrite0), .dac1out(out0), .dacbusy(busy0), .dacdone(done0));

    dac_writer_board #(.CLKDIV(1)) dut1 (
        .clk(clk), .reset(reset), .dac_enable(dac_enable), .dacdata(dacdata),
        .dacwrite(dacwrite1), .dac1out(out1), .dacbusy(busy1), .dacdone(done1));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done0[i] === 1'b1) done_cnt[i]++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dacwrite0 = '0;
        dacwrite1 = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    function automatic logic sn_of(input bit which);
        return which ? out1[0] : out0[0];
    endfunction

    // Waits (bounded by 'limit' cycles) for sync_n to fall, then rebuilds the
    // frame from din at each sclk rise. Returns at the negedge of the first
    // cycle with sync_n high again, where dacdone is sampled.
    task automatic get_frame(input bit which, input int limit,
                             output logic [15:0] f, output int lowc, output int waitc,
                             output int nbits, output int viol,
                             output logic [3:0] done_end, output bit ok);
        logic prev_sclk, prev_din, sc, d;
        f = '0; lowc = 0; waitc = 0; nbits = 0; viol = 0; done_end = '0; ok = 1'b1;
        @(negedge clk);
        while (sn_of(which) === 1'b1 && waitc < limit) begin
            waitc++;
            @(negedge clk);
        end
        if (waitc >= limit) begin
            ok = 1'b0;
            return;
        end
        prev_sclk = 1'b0;
        prev_din  = 1'b0;
        while (sn_of(which) === 1'b0 && lowc < 4000) begin
            sc = which ? out1[1] : out0[1];
            d  = which ? out1[2] : out0[2];
            if (sc && !prev_sclk) begin
                f = {f[14:0], d};
                nbits++;
            end else if (d !== prev_din) begin
                viol++;
            end
            prev_sclk = sc;
            prev_din  = d;
            lowc++;
            @(negedge clk);
        end
        done_end = which ? done1 : done0;
    endtask

    task automatic test_reset();
        int err;
        reset = 1'b1;
        dacdata = {4{16'h0FFF}};
        dacwrite0 = 4'hF;
        dacwrite1 = 4'hF;
        tick();
        checks++; if (out0 !== 3'b011) $display("FAIL reset_pins0: got %b expected %b", out0, 3'b011); else passed++;
        checks++; if (out1 !== 3'b011) $display("FAIL reset_pins1: got %b expected %b", out1, 3'b011); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else passed++;
        checks++; if (done0 !== 4'b0) $display("FAIL reset_done: got %b expected 0000", done0); else passed++;
        // Writes held only during the reset cycle must leave no request.
        reset = 1'b0;
        dacwrite0 = '0;
        dacwrite1 = '0;
        err = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || busy1 !== 1'b0 || out0[0] !== 1'b1) err++;
        end
        checks++; if (err != 0) $display("FAIL reset_req_ignored: got %0d busy cycles expected 0", err); else passed++;
    endtask

    task automatic test_single();
        logic [15:0] f; int lowc, waitc, nbits, viol; logic [3:0] de; bit ok;
        int d1;
        tick();
        d1 = done_cnt[1];
        dacdata[31:16] = 16'h0ABC;
        dacwrite0 = 4'b0010;
        tick();                          // edge k samples the write
        dacwrite0 = '0;
        tick();                          // edge k+1: LOAD
        checks++; if (out0[0] !== 1'b1) $display("FAIL lat_k1_sync: got %b expected 1", out0[0]); else passed++;
        checks++; if (busy0 !== 1'b1) $display("FAIL lat_k1_busy: got %b expected 1", busy0); else passed++;
        tick();                          // edge k+2: frame starts
        checks++; if (out0[0] !== 1'b0) $display("FAIL lat_k2_sync: got %b expected 0", out0[0]); else passed++;
        get_frame(1'b0, 10, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (!ok || f !== 16'h5ABC) $display("FAIL single_frame: got %h expected %h", f, 16'h5ABC); else passed++;
        checks++; if (lowc != 64) $display("FAIL single_low: got %0d expected 64", lowc); else passed++;
        checks++; if (nbits != 16 || viol != 0) $display("FAIL single_bits: got %0d bits %0d din changes expected 16 bits 0 changes", nbits, viol); else passed++;
        checks++; if (de !== 4'b0010) $display("FAIL single_done_gap1: got %b expected %b", de, 4'b0010); else passed++;
        repeat (3) @(negedge clk);       // fourth GAP cycle
        checks++; if (busy0 !== 1'b1 || out0 !== 3'b011) $display("FAIL single_gap4: got busy %b pins %b expected busy 1 pins 011", busy0, out0); else passed++;
        @(negedge clk);                  // IDLE
        checks++; if (busy0 !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy0); else passed++;
        checks++; if (done_cnt[1] - d1 != 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt[1] - d1); else passed++;
    endtask

    task automatic test_all_channels();
        logic [15:0] exp_f [4] = '{16'h1001, 16'h5002, 16'h9003, 16'hD004};
        logic [15:0] f; int lowc, waitc, nbits, viol; logic [3:0] de; bit ok;
        do_reset();
        dacdata = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        dacwrite0 = 4'hF;
        tick();
        dacwrite0 = '0;
        for (int i = 0; i < 4; i++) begin
            get_frame(1'b0, 50, f, lowc, waitc, nbits, viol, de, ok);
            checks++; if (!ok || f !== exp_f[i]) $display("FAIL rr_frame%0d: got %h expected %h", i, f, exp_f[i]); else passed++;
            checks++; if (lowc != 64 || de !== (4'b0001 << i)) $display("FAIL rr_low_done%0d: got %0d/%b expected 64/%b", i, lowc, de, 4'b0001 << i); else passed++;
            // sync_n-high interval = 4 GAP cycles + IDLE + LOAD; the first GAP
            // cycle was consumed by the previous call.
            if (i > 0) begin
                checks++; if (waitc + 1 != 6) $display("FAIL rr_gap%0d: got %0d expected 6", i, waitc + 1); else passed++;
            end
        end
    endtask

    task automatic test_overwrite();
        logic [15:0] f; int lowc, waitc, nbits, viol; logic [3:0] de; bit ok;
        int d2;
        d2 = done_cnt[2];
        dacdata[15:0] = 16'h0555;
        dacwrite0 = 4'b0001;
        tick();
        dacwrite0 = '0;
        fork
            get_frame(1'b0, 50, f, lowc, waitc, nbits, viol, de, ok);
            begin
                repeat (10) tick();
                dacdata[47:32] = 16'h0100;
                dacwrite0 = 4'b0100;
                tick();
                dacwrite0 = '0;
                repeat (5) tick();
                dacdata[47:32] = 16'h0200;
                dacwrite0 = 4'b0100;
                tick();
                dacwrite0 = '0;
            end
        join
        checks++; if (!ok || f !== 16'h1555) $display("FAIL ovw_ch0: got %h expected %h", f, 16'h1555); else passed++;
        get_frame(1'b0, 50, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (!ok || f !== 16'h9200) $display("FAIL ovw_ch2: got %h expected %h", f, 16'h9200); else passed++;
        get_frame(1'b0, 200, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (ok) $display("FAIL ovw_extra: got frame %h expected none", f); else passed++;
        checks++; if (done_cnt[2] - d2 != 1) $display("FAIL ovw_done_count: got %0d expected 1", done_cnt[2] - d2); else passed++;
    endtask

    task automatic test_enable();
        logic [15:0] f; int lowc, waitc, nbits, viol; logic [3:0] de; bit ok;
        int err;
        dac_enable = 4'b0111;
        dacdata[63:48] = 16'hFFFF;
        dacwrite0 = 4'b1000;
        tick();
        dacwrite0 = '0;
        err = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || out0[0] !== 1'b1) err++;
        end
        checks++; if (err != 0) $display("FAIL en_ignored: got %0d busy cycles expected 0", err); else passed++;
        tick();
        dac_enable = 4'hF;
        dacwrite0 = 4'b1000;
        tick();
        dacwrite0 = '0;
        get_frame(1'b0, 50, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (!ok || f !== 16'hDFFF) $display("FAIL en_frame: got %h expected %h", f, 16'hDFFF); else passed++;
        // Dropping enable[3] while channel 0 is in flight cancels channel 3.
        tick();
        dacdata[15:0]  = 16'h0123;
        dacdata[63:48] = 16'h0777;
        dacwrite0 = 4'b1001;
        tick();
        dacwrite0 = '0;
        fork
            get_frame(1'b0, 50, f, lowc, waitc, nbits, viol, de, ok);
            begin
                repeat (6) tick();
                dac_enable = 4'b0111;
                tick();
                dac_enable = 4'hF;
            end
        join
        checks++; if (!ok || f !== 16'h1123) $display("FAIL en_drop_ch0: got %h expected %h", f, 16'h1123); else passed++;
        get_frame(1'b0, 200, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (ok) $display("FAIL en_drop_ch3: got frame %h expected none", f); else passed++;
    endtask

    task automatic test_reset_midframe();
        int cnt, err;
        do_reset();
        dacdata[15:0]  = 16'h0AAA;
        dacdata[31:16] = 16'h0BBB;
        dacwrite0 = 4'b0011;
        tick();
        dacwrite0 = '0;
        cnt = 0;
        while (out0[0] === 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        repeat (32) tick();              // bits 0..7 sent, bit 8 on the wire
        checks++; if (out0[0] !== 1'b0) $display("FAIL mid_in_frame: got %b expected 0", out0[0]); else passed++;
        reset = 1'b1;
        tick();
        checks++; if (out0 !== 3'b011 || busy0 !== 1'b0 || done0 !== 4'b0) $display("FAIL mid_abort: got pins %b busy %b done %b expected 011 0 0000", out0, busy0, done0); else passed++;
        reset = 1'b0;
        err = 0;
        repeat (300) begin
            @(negedge clk);
            if (out0[0] !== 1'b1 || busy0 !== 1'b0 || done0 !== 4'b0) err++;
        end
        checks++; if (err != 0) $display("FAIL mid_quiet: got %0d active cycles expected 0", err); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] f; int lowc, waitc, nbits, viol; logic [3:0] de; bit ok;
        tick();
        dacdata[15:0] = 16'h0011;
        dacwrite1 = 4'b0001;
        tick();
        dacwrite1 = '0;
        fork
            get_frame(1'b1, 50, f, lowc, waitc, nbits, viol, de, ok);
            begin
                repeat (5) tick();
                dacdata[15:0] = 16'h0022;
                dacwrite1 = 4'b0001;
                tick();
                dacwrite1 = '0;
            end
        join
        checks++; if (!ok || f !== 16'h1011) $display("FAIL b2b_frame1: got %h expected %h", f, 16'h1011); else passed++;
        checks++; if (lowc != 32 || de !== 4'b0001) $display("FAIL b2b_low_done1: got %0d/%b expected 32/0001", lowc, de); else passed++;
        get_frame(1'b1, 50, f, lowc, waitc, nbits, viol, de, ok);
        checks++; if (!ok || f !== 16'h1022) $display("FAIL b2b_frame2: got %h expected %h", f, 16'h1022); else passed++;
        checks++; if (lowc != 32 || nbits != 16 || viol != 0) $display("FAIL b2b_shape2: got %0d low %0d bits %0d changes expected 32 16 0", lowc, nbits, viol); else passed++;
        // 2 GAP cycles + IDLE + LOAD between frames.
        checks++; if (waitc + 1 != 4) $display("FAIL b2b_gap: got %0d expected 4", waitc + 1); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_overwrite();
        test_enable();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
